sw_alloc_pipe: RTL

Parametrised, registered switch allocator for the VC router pipeline. It sits between buffer-write/route-compute and switch traversal. Each cycle it selects one VC per input port, then one input port per output port, using oldest-first priority with round-robin tie-break. It also assigns a downstream VC and tracks downstream credits internally, so no external credit snapshot is needed.

---
 rtl/sw_alloc_pipe.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sw_alloc_pipe.sv
// ---------------------------------------------------------------------------
// sw_alloc_pipe
//
// Registered separable switch allocator for the VC router pipeline. Each
// cycle it picks one VC per input port (stage A), then one input port per
// output port (stage B). Both stages use oldest-first priority, and ties go
// round-robin from a per-port pointer. It also picks a downstream VC for
// every granted output and keeps the downstream credit counters itself.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high
//   req_in         : one-hot requested output per (input port, VC); zero = idle
//   time_in        : age stamp per (input port, VC); smaller = older
//   credit_ret_in  : credit return pulse per (output port, downstream VC)
//   grant_valid_out: output o granted this cycle
//   sel_pc_out     : winning input port per output
//   sel_vc_out     : winning input VC per output
//   vc_new_out     : downstream VC assigned per output
//   deq_out        : pop pulse for the granted input VC
//   credit_err_out : sticky, a credit came back to a full counter
// ---------------------------------------------------------------------------
module sw_alloc_pipe #(
  parameter int NUM_PORT     = 5,
  parameter int NUM_VC       = 4,
  parameter int TIME_WIDTH   = 8,
  parameter int CREDIT_DEPTH = 4,
  localparam int PCW = $clog2(NUM_PORT),
  localparam int VCW = $clog2(NUM_VC),
  localparam int CW  = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORT*NUM_VC*NUM_PORT-1:0]  req_in,
  input  logic [NUM_PORT*NUM_VC*TIME_WIDTH-1:0] time_in,
  input  logic [NUM_PORT*NUM_VC-1:0]           credit_ret_in,
  output logic [NUM_PORT-1:0]                  grant_valid_out,
  output logic [NUM_PORT*PCW-1:0]              sel_pc_out,
  output logic [NUM_PORT*VCW-1:0]              sel_vc_out,
  output logic [NUM_PORT*VCW-1:0]              vc_new_out,
  output logic [NUM_PORT*NUM_VC-1:0]           deq_out,
  output logic                                 credit_err_out
);

  localparam int NPV = NUM_PORT * NUM_VC;

  // Decoded requests
  logic [NPV-1:0]        w_reqAny;
  logic [PCW-1:0]        w_reqOut  [NPV];
  logic [TIME_WIDTH-1:0] w_time    [NPV];

  // Credit availability and downstream VC choice per output
  logic [NUM_PORT-1:0]   w_outOk;
  logic [VCW-1:0]        w_vcNew   [NUM_PORT];

  // Stage A winners per input port
  logic [NUM_PORT-1:0]   w_aValid;
  logic [VCW-1:0]        w_aVc     [NUM_PORT];
  logic [PCW-1:0]        w_aOut    [NUM_PORT];
  logic [TIME_WIDTH-1:0] w_aTime   [NUM_PORT];

  // Stage B winners per output port
  logic [NUM_PORT-1:0]   w_bValid;
  logic [PCW-1:0]        w_bPc     [NUM_PORT];
  logic [VCW-1:0]        w_bVc     [NUM_PORT];

  // Grant fan-out back to inputs and to credit counters
  logic [NUM_PORT-1:0]   w_inWon;
  logic [VCW-1:0]        w_inWonVc [NUM_PORT];
  logic [NPV-1:0]        w_deq;
  logic [NPV-1:0]        w_dec;

  // State
  logic [CW-1:0]         r_cnt     [NUM_PORT][NUM_VC];
  logic [VCW-1:0]        r_inPtr   [NUM_PORT];
  logic [PCW-1:0]        r_outPtr  [NUM_PORT];
  logic [NUM_PORT-1:0]   r_grantValid;
  logic [NUM_PORT*PCW-1:0] r_selPc;
  logic [NUM_PORT*VCW-1:0] r_selVc;
  logic [NUM_PORT*VCW-1:0] r_vcNew;
  logic [NPV-1:0]        r_deq;
  logic                  r_creditErr;

  // Request decode. A multi-hot request keeps only its lowest set bit, so
  // the scan runs from the top and the last hit wins.
  always_comb begin
    for (int i = 0; i < NPV; i++) begin
      w_reqAny[i] = 1'b0;
      w_reqOut[i] = '0;
      w_time[i]   = time_in[i*TIME_WIDTH +: TIME_WIDTH];
      for (int o = NUM_PORT - 1; o >= 0; o--) begin
        if (req_in[i*NUM_PORT + o]) begin
          w_reqAny[i] = 1'b1;
          w_reqOut[i] = PCW'(o);
        end
      end
    end
  end

  // An output can accept traffic when any downstream VC has credit. The
  // downstream VC handed out is the lowest one with credit.
  always_comb begin
    for (int o = 0; o < NUM_PORT; o++) begin
      w_outOk[o] = 1'b0;
      w_vcNew[o] = '0;
      for (int w = NUM_VC - 1; w >= 0; w--) begin
        if (r_cnt[o][w] != '0) begin
          w_outOk[o] = 1'b1;
          w_vcNew[o] = VCW'(w);
        end
      end
    end
  end

  // Stage A: the oldest eligible VC per input. The scan starts at the input
  // pointer and a later VC replaces the current best only when it is
  // strictly older. On a tie the first VC found from the pointer wins.
  always_comb begin
    logic                  found;
    logic [TIME_WIDTH-1:0] best;
    logic [VCW-1:0]        bestVc;
    logic [PCW-1:0]        bestOut;
    int                    v;
    int                    idx;
    for (int p = 0; p < NUM_PORT; p++) begin
      found   = 1'b0;
      best    = '0;
      bestVc  = '0;
      bestOut = '0;
      for (int k = 0; k < NUM_VC; k++) begin
        v   = (int'(r_inPtr[p]) + k) % NUM_VC;
        idx = p * NUM_VC + v;
        if (w_reqAny[idx] && w_outOk[w_reqOut[idx]] &&
            (!found || (w_time[idx] < best))) begin
          found   = 1'b1;
          best    = w_time[idx];
          bestVc  = VCW'(v);
          bestOut = w_reqOut[idx];
        end
      end
      w_aValid[p] = found;
      w_aVc[p]    = bestVc;
      w_aOut[p]   = bestOut;
      w_aTime[p]  = best;
    end
  end

  // Stage B: the oldest stage-A winner per output. Ties are broken the same
  // circular way, starting from the output pointer.
  always_comb begin
    logic                  found;
    logic [TIME_WIDTH-1:0] best;
    logic [PCW-1:0]        bestPc;
    logic [VCW-1:0]        bestVc;
    int                    p;
    for (int o = 0; o < NUM_PORT; o++) begin
      found  = 1'b0;
      best   = '0;
      bestPc = '0;
      bestVc = '0;
      for (int k = 0; k < NUM_PORT; k++) begin
        p = (int'(r_outPtr[o]) + k) % NUM_PORT;
        if (w_aValid[p] && (w_aOut[p] == PCW'(o)) &&
            (!found || (w_aTime[p] < best))) begin
          found  = 1'b1;
          best   = w_aTime[p];
          bestPc = PCW'(p);
          bestVc = w_aVc[p];
        end
      end
      w_bValid[o] = found;
      w_bPc[o]    = bestPc;
      w_bVc[o]    = bestVc;
    end
  end

  // Map each output grant back to its input (pop pulse, input pointer) and
  // to the credit counter it consumes.
  always_comb begin
    w_inWon = '0;
    w_deq   = '0;
    w_dec   = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      w_inWonVc[p] = '0;
    end
    for (int o = 0; o < NUM_PORT; o++) begin
      if (w_bValid[o]) begin
        w_inWon[w_bPc[o]]   = 1'b1;
        w_inWonVc[w_bPc[o]] = w_bVc[o];
        w_deq[int'(w_bPc[o]) * NUM_VC + int'(w_bVc[o])] = 1'b1;
        w_dec[o * NUM_VC + int'(w_vcNew[o])]            = 1'b1;
      end
    end
  end

  // Grant registers, round-robin pointers and credit counters all update on
  // the same edge, so the next decision already sees the consumed credit.
  // A grant and a return on the same counter cancel. A return to a full
  // counter saturates and raises the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grantValid <= '0;
      r_selPc      <= '0;
      r_selVc      <= '0;
      r_vcNew      <= '0;
      r_deq        <= '0;
      r_creditErr  <= 1'b0;
      for (int o = 0; o < NUM_PORT; o++) begin
        r_outPtr[o] <= '0;
        r_inPtr[o]  <= '0;
        for (int w = 0; w < NUM_VC; w++) begin
          r_cnt[o][w] <= CW'(CREDIT_DEPTH);
        end
      end
    end else begin
      r_grantValid <= w_bValid;
      r_deq        <= w_deq;
      for (int o = 0; o < NUM_PORT; o++) begin
        r_selPc[o*PCW +: PCW] <= w_bValid[o] ? w_bPc[o]   : '0;
        r_selVc[o*VCW +: VCW] <= w_bValid[o] ? w_bVc[o]   : '0;
        r_vcNew[o*VCW +: VCW] <= w_bValid[o] ? w_vcNew[o] : '0;
        if (w_bValid[o]) begin
          r_outPtr[o] <= (w_bPc[o] == PCW'(NUM_PORT - 1)) ? '0 : w_bPc[o] + 1'b1;
        end
      end
      for (int p = 0; p < NUM_PORT; p++) begin
        if (w_inWon[p]) begin
          r_inPtr[p] <= (w_inWonVc[p] == VCW'(NUM_VC - 1)) ? '0 : w_inWonVc[p] + 1'b1;
        end
      end
      for (int o = 0; o < NUM_PORT; o++) begin
        for (int w = 0; w < NUM_VC; w++) begin
          if (credit_ret_in[o*NUM_VC + w] && !w_dec[o*NUM_VC + w]) begin
            if (r_cnt[o][w] == CW'(CREDIT_DEPTH)) begin
              r_creditErr <= 1'b1;
            end else begin
              r_cnt[o][w] <= r_cnt[o][w] + 1'b1;
            end
          end else if (w_dec[o*NUM_VC + w] && !credit_ret_in[o*NUM_VC + w]) begin
            r_cnt[o][w] <= r_cnt[o][w] - 1'b1;
          end
        end
      end
    end
  end

  assign grant_valid_out = r_grantValid;
  assign sel_pc_out      = r_selPc;
  assign sel_vc_out      = r_selVc;
  assign vc_new_out      = r_vcNew;
  assign deq_out         = r_deq;
  assign credit_err_out  = r_creditErr;

endmodule
